// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Ports: clk, rst (async high), start, bin_in -> busy, done, bcd_out, overflow.
module bin_to_bcd_seq #(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 5,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t              state;
    logic [IN_WIDTH-1:0] sr;
    logic [BW-1:0]       scratch;
    logic [BW-1:0]       adj;
    logic [BW-1:0]       scr_next;
    logic [BW-1:0]       result;
    logic                sticky;
    logic [CW-1:0]       cnt;

    // Add-3 correction on every digit, all from the pre-shift value.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // Shift the corrected digits left; input MSB enters digit 0.
    assign scr_next = {adj[BW-2:0], sr[IN_WIDTH-1]};

    generate
        if (BLANK_LZ != 0) begin : g_blank
            logic lead;
            // Top-down: zero digits become 4'hF until the first non-zero.
            // Digit 0 is excluded so a zero value still shows one "0".
            always_comb begin
                result = scratch;
                lead   = 1'b1;
                for (int i = DIGITS - 1; i >= 1; i--) begin
                    if (lead && (scratch[4*i +: 4] == 4'd0))
                        result[4*i +: 4] = 4'hF;
                    else
                        lead = 1'b0;
                end
            end
        end else begin : g_noblank
            assign result = scratch;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            scratch  <= '0;
            sticky   <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sr      <= bin_in;
                        scratch <= '0;
                        sticky  <= 1'b0;
                        cnt     <= CW'(IN_WIDTH);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr      <= sr << 1;
                    scratch <= scr_next;
                    // A set bit leaving the top digit means the value
                    // does not fit in DIGITS digits.
                    if (adj[BW-1])
                        sticky <= 1'b1;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= FINISH;
                end
                FINISH: begin
                    bcd_out  <= result;
                    overflow <= sticky;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: three configurations
// (default, leading-zero blanking, 4-digit) with a result scoreboard.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_v [3];
    logic [15:0] bin_v   [3];

    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic        ovf0, ovf1, ovf2;
    logic [19:0] bcd0, bcd1;
    logic [15:0] bcd2;

    bin_to_bcd_seq #(.IN_WIDTH(16), .DIGITS(5), .BLANK_LZ(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .bin_in(bin_v[0]),
        .busy(busy0), .done(done0), .bcd_out(bcd0), .overflow(ovf0));

    bin_to_bcd_seq #(.IN_WIDTH(16), .DIGITS(5), .BLANK_LZ(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .bin_in(bin_v[1]),
        .busy(busy1), .done(done1), .bcd_out(bcd1), .overflow(ovf1));

    bin_to_bcd_seq #(.IN_WIDTH(16), .DIGITS(4), .BLANK_LZ(0)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .bin_in(bin_v[2]),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2));

    typedef struct {
        int          k;
        logic [19:0] bcd;
        logic        ovf;
        bit          chk_bcd;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic get_busy(int k);
        case (k)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_done(int k);
        case (k)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic get_ovf(int k);
        case (k)
            0: return ovf0;
            1: return ovf1;
            default: return ovf2;
        endcase
    endfunction

    function automatic logic [19:0] get_bcd(int k);
        case (k)
            0: return bcd0;
            1: return bcd1;
            default: return {4'h0, bcd2};
        endcase
    endfunction

    task automatic check(string tag, logic [19:0] obs, logic [19:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done; cyc counts negedges after the drive edge.
    task automatic wait_done(input int k, input string tag,
                             input logic keep, input logic [15:0] nb,
                             input bit noise,
                             output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (get_busy(k)) bcnt++;
            if (cyc == 1) begin
                start_v[k] = keep;
                bin_v[k]   = nb;
            end
            if (noise && cyc == 5) start_v[k] = 1'b1;
            if (noise && cyc == 6) start_v[k] = 1'b0;
        end while (!get_done(k) && cyc < 60);
        check({tag, "_done_seen"}, 20'(get_done(k)), 20'd1);
    endtask

    task automatic pop_check(int k);
        exp_t e;
        tests++;
        assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL sb_empty: observed %0d expected >0", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, "_inst"}, 20'(k), 20'(e.k));
            if (e.chk_bcd)
                check({e.tag, "_bcd"}, get_bcd(k), e.bcd);
            check({e.tag, "_ovf"}, 20'(get_ovf(k)), 20'(e.ovf));
        end
    endtask

    task automatic run(int k, logic [15:0] v, logic [19:0] eb, logic eo,
                       bit cb, bit noise, string tag);
        int cyc, bcnt;
        @(negedge clk);
        start_v[k] = 1'b1;
        bin_v[k]   = v;
        sb.push_back('{k, eb, eo, cb, tag});
        wait_done(k, tag, 1'b0, ~v, noise, cyc, bcnt);
        pop_check(k);
        check({tag, "_lat"}, 20'(cyc - 1), 20'd17);
        check({tag, "_busy"}, 20'(bcnt), 20'd17);
        @(negedge clk);
        check({tag, "_done_1cyc"}, 20'(get_done(k)), 20'd0);
    endtask

    initial begin
        int cyc, bcnt, gap, ndone;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            bin_v[i]   = '0;
        end
        #1;
        check("rst_busy", {17'd0, busy2, busy1, busy0}, 20'd0);
        check("rst_done", {17'd0, done2, done1, done0}, 20'd0);
        check("rst_ovf", {17'd0, ovf2, ovf1, ovf0}, 20'd0);
        check("rst_bcd0", bcd0, 20'd0);
        check("rst_bcd1", bcd1, 20'd0);
        check("rst_bcd2", {4'h0, bcd2}, 20'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Default config, including ignored mid-conversion start pulse.
        run(0, 16'd1234, 20'h01234, 1'b0, 1'b1, 1'b1, "d_1234");
        repeat (4) @(negedge clk);
        check("d_hold_bcd", bcd0, 20'h01234);
        check("d_no_extra_done", 20'(done0), 20'd0);
        run(0, 16'hFFFF, 20'h65535, 1'b0, 1'b1, 1'b0, "d_65535");
        run(0, 16'd0, 20'h00000, 1'b0, 1'b1, 1'b0, "d_0");

        // Leading-zero blanking.
        run(1, 16'd1234, 20'hF1234, 1'b0, 1'b1, 1'b0, "b_1234");
        run(1, 16'd0, 20'hFFFF0, 1'b0, 1'b1, 1'b0, "b_0");
        run(1, 16'd50000, 20'h50000, 1'b0, 1'b1, 1'b0, "b_50000");
        run(1, 16'd305, 20'hFF305, 1'b0, 1'b1, 1'b0, "b_305");

        // Four digits: overflow detection.
        run(2, 16'd12345, 20'h0, 1'b1, 1'b0, 1'b0, "o_12345");
        run(2, 16'd9999, 20'h09999, 1'b0, 1'b1, 1'b0, "o_9999");
        run(2, 16'd10000, 20'h0, 1'b1, 1'b0, 1'b0, "o_10000");

        // start held high: back-to-back acceptance on the done cycle.
        @(negedge clk);
        start_v[0] = 1'b1;
        bin_v[0]   = 16'd7;
        sb.push_back('{0, 20'h00007, 1'b0, 1'b1, "bb_7"});
        sb.push_back('{0, 20'h00042, 1'b0, 1'b1, "bb_42"});
        wait_done(0, "bb_7", 1'b1, 16'd42, 1'b0, cyc, bcnt);
        pop_check(0);
        wait_done(0, "bb_42", 1'b0, 16'd3, 1'b0, gap, bcnt);
        pop_check(0);
        check("bb_gap", 20'(gap), 20'd18);

        // Reset mid-conversion.
        @(negedge clk);
        start_v[0] = 1'b1;
        bin_v[0]   = 16'd65535;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("r_busy", 20'(busy0), 20'd0);
        check("r_done", 20'(done0), 20'd0);
        check("r_bcd", bcd0, 20'd0);
        check("r_ovf", 20'(ovf0), 20'd0);
        ndone = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        check("r_no_done", 20'(ndone), 20'd0);
        run(0, 16'd99, 20'h00099, 1'b0, 1'b1, 1'b0, "r_99");

        check("sb_drained", 20'(sb.size()), 20'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Produces packed BCD digits for the per-digit seven-segment decoders on the board display path.
- Input comes from processor-side values such as register contents or the PC.
- Optional leading-zero blanking drives 4'hF into unused digits; the segment decoder maps any non-BCD code to all segments off.

Parameters:
IN_WIDTH, 16, width of the binary input value (>= 1)
DIGITS, 5, number of BCD output digits (>= 1)
BLANK_LZ, 0, 1 = replace leading zero digits with 4'hF on bcd_out (digit 0 never blanked)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request conversion of bin_in; sampled only in IDLE
bin_in  input  IN_WIDTH  unsigned binary value, captured on the accepting edge
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd_out/overflow are updated
bcd_out  output  4*DIGITS  packed BCD result; digit 0 = bits [3:0] (units)
overflow  output  1  result did not fit in DIGITS digits; valid with bcd_out

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, bcd_out=0, overflow=0; internal shift register, scratch digits and bit counter cleared.
- States: IDLE, SHIFT, FINISH.
- IDLE, start=1 at edge E0:
  - latch bin_in into shift register; clear scratch digits and sticky overflow;
  - counter=IN_WIDTH; go to SHIFT; busy=1 from E0.
- IDLE, start=0: hold all outputs; done=0.
- SHIFT, each edge:
  - every scratch digit >= 5 gets +3 (all digits adjusted in parallel from the pre-shift value);
  - {scratch, shift register} shifts left by 1; MSB of shift register enters digit 0 LSB;
  - a 1 shifted out of the top digit sets sticky overflow;
  - counter decrements; the edge that takes it to 0 moves to FINISH.
  - Edges E1..E_IN_WIDTH.
- FINISH, edge E_(IN_WIDTH+1):
  - bcd_out <= scratch, with blanking applied if BLANK_LZ=1;
  - overflow <= sticky flag; done=1 for exactly this next cycle; busy=0; go to IDLE.
- Latency: done high in the cycle after E_(IN_WIDTH+1), i.e. IN_WIDTH+1 edges after the accepting edge. Default: 17.
- Blanking (BLANK_LZ=1): scanning from the top digit down, each zero digit becomes 4'hF until the first non-zero digit. Digit 0 always shows its value, so 0 displays as one "0".
- Boundary conditions:
  - start while busy: ignored, no queuing.
  - start high in the done cycle: accepted (state is IDLE), so back-to-back conversions are possible.
  - bin_in changes after the accepting edge: no effect.
  - bcd_out/overflow hold their last result until the next FINISH.
  - reset mid-conversion: aborts, outputs cleared, done never pulses.
  - IN_WIDTH=1: one SHIFT edge.
  - Overflow is impossible if DIGITS >= ceil(IN_WIDTH*log10(2)); it must still be computed generically.
- Digits never hold values > 9 unless overflow=1 or blanked (4'hF).

Test Plan:
1. Defaults, BLANK_LZ=0, bin_in=16'd1234, start pulse -> done pulses 17 cycles later; bcd_out=20'h01234, overflow=0, busy high for exactly 17 cycles.
2. bin_in=16'hFFFF -> bcd_out=20'h65535, overflow=0; then bin_in=0 -> bcd_out=20'h00000.
3. BLANK_LZ=1: bin_in=1234 -> 20'hF1234; bin_in=0 -> 20'hFFFF0; bin_in=50000 -> 20'h50000 (internal zeros kept).
4. DIGITS=4, IN_WIDTH=16, bin_in=12345 -> overflow=1 with done; bin_in=9999 -> bcd_out=16'h9999, overflow=0.
5. start held high continuously, values 7 then 42 -> second conversion starts on the done cycle; results 20'h00007 then 20'h00042. start pulses mid-conversion are ignored.
6. Assert rst at cycle 8 of a conversion of 65535 -> busy=0, done=0, bcd_out=0 immediately. After release, a new start with 99 -> 20'h00099.
